mcp47feb_dac_scheduler: RTL and testbench

- Owns the shared i2c_master command/data streams on behalf of the two MCP47FEB DAC channels (DAC0_REG, DAC1_REG).
- Users post 12-bit channel updates at any rate; each channel has a shadow register with a dirty flag, so repeated writes to a pending channel coalesce.
- A round-robin scheduler turns dirty channels into complete 3-byte I2C write frames with full valid/ready handshakes.
- Replaces ad-hoc DAC sequencing in the top-level test FSM; sits between application logic and i2c_master at clk (100 MHz).

---
 rtl/mcp47feb_dac_scheduler_if.sv | 34 +++
 rtl/mcp47feb_dac_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_mcp47feb_dac_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp47feb_dac_scheduler_if.sv
// ---------------------------------------------------------------------------
// mcp47feb_dac_scheduler_if
// Command and write-data streams between the MCP47FEB DAC scheduler and
// i2c_master, plus the master's busy/missed_ack status.
//   master modport : scheduler side (drives cmd_* and data_in*)
//   slave modport  : i2c_master side (drives cmd_ready, data_in_ready,
//                    i2c_busy, missed_ack)
// ---------------------------------------------------------------------------
interface mcp47feb_dac_scheduler_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_last;
  logic       data_in_ready;
  logic       i2c_busy;
  logic       missed_ack;

  modport master (
    output cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
    output data_in, data_in_valid, data_in_last,
    input  cmd_ready, data_in_ready, i2c_busy, missed_ack
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
    input  data_in, data_in_valid, data_in_last,
    output cmd_ready, data_in_ready, i2c_busy, missed_ack
  );
endinterface

// File: rtl/mcp47feb_dac_scheduler.sv
// ---------------------------------------------------------------------------
// mcp47feb_dac_scheduler
// Shadows the two MCP47FEB DAC channel codes, coalesces repeated updates to a
// channel that is still pending, and turns dirty channels into 3-byte I2C
// write frames on the shared i2c_master streams using round-robin arbitration.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   wr_en/wr_channel/wr_value   shadow register write (always accepted)
//   pending          dirty flag per channel
//   sched_ready      sticky: DAC power-up delay has elapsed
//   done             1-cycle pulse at the end of a frame
//   done_channel     channel of the last completed frame
//   done_nack        qualifies done: the frame saw a missed ACK
//   err_count        saturating count of failed frames
//   i2c              i2c_master command/data streams and status (master side)
//
// Optional build macro: DAC_SCHED_RETRY_EN
//   When defined, a NACKed frame is re-sent up to MAX_RETRY times before it is
//   reported; otherwise every NACKed frame completes with done_nack = 1.
// ---------------------------------------------------------------------------
module mcp47feb_dac_scheduler #(
  parameter int         STARTUP_CYCLES = 100000,
  parameter logic [6:0] DEV_ADDR       = 7'b110_0000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_channel,
  input  logic [11:0] wr_value,
  output logic [1:0]  pending,
  output logic        sched_ready,
  output logic        done,
  output logic        done_channel,
  output logic        done_nack,
  output logic [7:0]  err_count,
  mcp47feb_dac_scheduler_if.master i2c
);

  localparam logic [2:0] ST_STARTUP = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_B0      = 3'd3;
  localparam logic [2:0] ST_B1      = 3'd4;
  localparam logic [2:0] ST_B2      = 3'd5;
  localparam logic [2:0] ST_WAIT    = 3'd6;

  localparam int CNT_W = $clog2(STARTUP_CYCLES + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] startup_cnt;
  logic [1:0][11:0] shadow;
  logic             last;
  logic             tx_ch;
  logic [11:0]      tx_value;
  logic             nack_seen;

  logic             sel_ch;
  logic             start_frame;
  logic [1:0]       pending_nxt;
  logic             in_frame;
  logic             frame_nack;
  logic             wait_exit;
  logic             retry_go;

  // Both dirty: alternate away from the last served channel.
  assign sel_ch      = (pending == 2'b11) ? ~last : pending[1];
  assign start_frame = (state == ST_IDLE) && (pending != 2'b00);
  assign in_frame    = (state == ST_CMD) || (state == ST_B0) || (state == ST_B1) ||
                       (state == ST_B2)  || (state == ST_WAIT);
  // A missed ACK in the exit cycle itself still belongs to this frame.
  assign frame_nack  = nack_seen | i2c.missed_ack;
  assign wait_exit   = (state == ST_WAIT) && !i2c.i2c_busy && i2c.cmd_ready;

  // Select clears the flag, but a write landing in the same cycle re-sets it
  // so the newer value is sent in a following frame.
  always_comb begin
    pending_nxt = pending;
    if (start_frame) pending_nxt[sel_ch] = 1'b0;
    if (wr_en)       pending_nxt[wr_channel] = 1'b1;
  end

`ifdef DAC_SCHED_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt;

  assign retry_go = wait_exit && frame_nack && (retry_cnt != RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= '0;
    end else if (start_frame) begin
      retry_cnt <= '0;
    end else if (retry_go) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_go = 1'b0;
`endif

  // Stream outputs decode straight from state so an asynchronous reset drops
  // every valid immediately.
  assign i2c.cmd_valid          = (state == ST_CMD);
  assign i2c.cmd_start          = (state == ST_CMD);
  assign i2c.cmd_write_multiple = (state == ST_CMD);
  assign i2c.cmd_stop           = (state == ST_CMD);
  assign i2c.cmd_address        = (state == ST_CMD) ? DEV_ADDR : 7'd0;
  assign i2c.data_in_valid      = (state == ST_B0) || (state == ST_B1) || (state == ST_B2);
  assign i2c.data_in_last       = (state == ST_B2);

  always_comb begin
    i2c.data_in = 8'h00;
    case (state)
      ST_B0:   i2c.data_in = {4'b0000, tx_ch, 2'b00, 1'b0};
      ST_B1:   i2c.data_in = {4'b0000, tx_value[11:8]};
      ST_B2:   i2c.data_in = tx_value[7:0];
      default: i2c.data_in = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_STARTUP;
      startup_cnt  <= '0;
      sched_ready  <= 1'b0;
      pending      <= 2'b00;
      shadow       <= '0;
      last         <= 1'b1;
      tx_ch        <= 1'b0;
      tx_value     <= 12'd0;
      nack_seen    <= 1'b0;
      done         <= 1'b0;
      done_channel <= 1'b0;
      done_nack    <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      done    <= 1'b0;
      pending <= pending_nxt;
      if (wr_en) shadow[wr_channel] <= wr_value;
      // Set first; a CMD-entry clear below takes priority.
      if (in_frame && i2c.missed_ack) nack_seen <= 1'b1;

      case (state)
        ST_STARTUP: begin
          if (startup_cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
            sched_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            startup_cnt <= startup_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (start_frame) begin
            tx_value  <= shadow[sel_ch];
            tx_ch     <= sel_ch;
            last      <= sel_ch;
            nack_seen <= 1'b0;
            state     <= ST_CMD;
          end
        end
        ST_CMD:  if (i2c.cmd_ready)     state <= ST_B0;
        ST_B0:   if (i2c.data_in_ready) state <= ST_B1;
        ST_B1:   if (i2c.data_in_ready) state <= ST_B2;
        ST_B2:   if (i2c.data_in_ready) state <= ST_WAIT;
        ST_WAIT: begin
          if (retry_go) begin
            nack_seen <= 1'b0;
            state     <= ST_CMD;
          end else if (wait_exit) begin
            done         <= 1'b1;
            done_channel <= tx_ch;
            done_nack    <= frame_nack;
            if (frame_nack && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp47feb_dac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mcp47feb_dac_scheduler
// Directed and randomized checks of the DAC scheduler against a channel-level
// reference model (shadow codes, dirty flags, round-robin owner, error count).
// The bench plays the i2c_master role; all driving and sampling happens on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mcp47feb_dac_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        wr_channel;
  logic [11:0] wr_value;
  logic [1:0]  pending;
  logic        sched_ready;
  logic        done;
  logic        done_channel;
  logic        done_nack;
  logic [7:0]  err_count;

  mcp47feb_dac_scheduler_if bus();

  mcp47feb_dac_scheduler #(
    .STARTUP_CYCLES(100),
    .DEV_ADDR(7'b110_0000),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_channel(wr_channel),
    .wr_value(wr_value),
    .pending(pending),
    .sched_ready(sched_ready),
    .done(done),
    .done_channel(done_channel),
    .done_nack(done_nack),
    .err_count(err_count),
    .i2c(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [11:0] m_shadow [2];
  bit          m_pend [2];
  bit          m_last;
  int          m_err;

  // Writes to inject while a frame sits stalled in B1
  bit          wq_ch [$];
  logic [11:0] wq_v  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_shadow[0] = 12'd0; m_shadow[1] = 12'd0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_last = 1'b1;
    m_err = 0;
  endtask

  task automatic wr(input bit ch, input logic [11:0] v);
    wr_en = 1'b1; wr_channel = ch; wr_value = v;
    tick();
    wr_en = 1'b0;
    m_shadow[ch] = v;
    m_pend[ch] = 1'b1;
  endtask

  // Next frame owner: the only dirty channel, or the one not served last.
  task automatic predict(output bit ch, output logic [11:0] v);
    if (m_pend[0] && m_pend[1]) ch = ~m_last;
    else ch = m_pend[1];
    v = m_shadow[ch];
    m_pend[ch] = 1'b0;
    m_last = ch;
  endtask

  task automatic do_cmd(input int stall);
    int t = 0;
    while (!bus.cmd_valid && t < 300) begin tick(); t++; end
    chk("cmd_valid", {31'd0, bus.cmd_valid}, 1);
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    chk("cmd_valid_held", {31'd0, bus.cmd_valid}, 1);
    chk("cmd_address", {25'd0, bus.cmd_address}, 32'h60);
    chk("cmd_flags", {29'd0, bus.cmd_start, bus.cmd_write_multiple, bus.cmd_stop}, 3'b111);
    bus.cmd_ready = 1'b1;
    bus.i2c_busy  = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk("cmd_valid_drop", {31'd0, bus.cmd_valid}, 0);
  endtask

  task automatic do_byte(input string tag, input logic [7:0] exp, input bit lst,
                         input int stall, input bit nack);
    chk({tag, "_valid"}, {31'd0, bus.data_in_valid}, 1);
    chk({tag, "_data"}, {24'd0, bus.data_in}, {24'd0, exp});
    chk({tag, "_last"}, {31'd0, bus.data_in_last}, {31'd0, lst});
    bus.data_in_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (wq_ch.size() > 0) wr(wq_ch.pop_front(), wq_v.pop_front());
      else tick();
    end
    if (stall > 0) begin
      chk({tag, "_stall_valid"}, {31'd0, bus.data_in_valid}, 1);
      chk({tag, "_stall_data"}, {24'd0, bus.data_in}, {24'd0, exp});
    end
    bus.data_in_ready = 1'b1;
    bus.missed_ack    = nack;
    tick();
    bus.data_in_ready = 1'b0;
    bus.missed_ack    = 1'b0;
  endtask

  task automatic do_bytes(input bit ch, input logic [11:0] v, input int b1_stall, input bit nack);
    do_byte("b0", {4'b0000, ch, 3'b000}, 1'b0, 0, nack);
    do_byte("b1", {4'b0000, v[11:8]}, 1'b0, b1_stall, nack);
    do_byte("b2", v[7:0], 1'b1, 0, nack);
  endtask

  task automatic finish_frame(input bit ch, input bit nack);
    tick();
    chk("done_early", {31'd0, done}, 0);
    bus.cmd_ready = 1'b1;
    tick();
    chk("done_while_busy", {31'd0, done}, 0);
    bus.i2c_busy = 1'b0;
    tick();
    bus.cmd_ready = 1'b0;
    if (nack && m_err < 255) m_err++;
    chk("done", {31'd0, done}, 1);
    chk("done_channel", {31'd0, done_channel}, {31'd0, ch});
    chk("done_nack", {31'd0, done_nack}, {31'd0, nack});
    chk("err_count", {24'd0, err_count}, m_err);
    chk("pending_after", {30'd0, pending}, {30'd0, m_pend[1], m_pend[0]});
    tick();
    chk("done_pulse_end", {31'd0, done}, 0);
  endtask

  task automatic run_frame(input int cmd_stall, input int b1_stall, input bit nack);
    bit ch; logic [11:0] v;
    predict(ch, v);
    do_cmd(cmd_stall);
    do_bytes(ch, v, b1_stall, nack);
    finish_frame(ch, nack);
  endtask

`ifdef DAC_SCHED_RETRY_EN
  task automatic run_retry_frame();
    bit ch; logic [11:0] v;
    predict(ch, v);
    for (int a = 0; a < 4; a++) begin
      do_cmd(0);
      do_bytes(ch, v, 0, 1'b1);
      if (a < 3) begin
        bus.i2c_busy  = 1'b0;
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        chk("retry_no_done", {31'd0, done}, 0);
      end
    end
    finish_frame(ch, 1'b1);
  endtask
`endif

  initial begin
    bit          ch6;
    logic [11:0] v6;
    int          t;

    rst = 1'b0; wr_en = 1'b0; wr_channel = 1'b0; wr_value = 12'd0;
    bus.cmd_ready = 1'b0; bus.data_in_ready = 1'b0;
    bus.i2c_busy = 1'b0; bus.missed_ack = 1'b0;
    model_reset();
    repeat (3) tick();

    chk("rst_pending", {30'd0, pending}, 0);
    chk("rst_sched_ready", {31'd0, sched_ready}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    chk("rst_cmd_valid", {31'd0, bus.cmd_valid}, 0);
    chk("rst_cmd_address", {25'd0, bus.cmd_address}, 0);
    chk("rst_data_valid", {31'd0, bus.data_in_valid}, 0);

    // Startup delay and first frame; write lands on cycle 5.
    rst = 1'b1;
    repeat (4) tick();
    wr(1'b0, 12'hABC);
    chk("pending_startup", {30'd0, pending}, 2'b01);
    repeat (94) tick();
    chk("sched_ready_c99", {31'd0, sched_ready}, 0);
    tick();
    chk("sched_ready_c100", {31'd0, sched_ready}, 1);
    chk("no_cmd_c100", {31'd0, bus.cmd_valid}, 0);
    tick();
    chk("cmd_valid_c101", {31'd0, bus.cmd_valid}, 1);
    run_frame(3, 0, 1'b0);

    // Write-to-cmd_valid latency on an idle bus, with long stalls.
    tick();
    wr(1'b1, 12'h5A7);
    tick();
    chk("latency_2cyc", {31'd0, bus.cmd_valid}, 1);
    run_frame(6, 10, 1'b0);

    // Coalescing: three ch1 writes while a ch0 frame sits in B1.
    wr(1'b0, 12'h3C4);
    wq_ch.push_back(1'b1); wq_v.push_back(12'h001);
    wq_ch.push_back(1'b1); wq_v.push_back(12'h002);
    wq_ch.push_back(1'b1); wq_v.push_back(12'h003);
    run_frame(0, 4, 1'b0);
    run_frame(0, 0, 1'b0);
    repeat (5) tick();
    chk("coalesce_single", {31'd0, bus.cmd_valid}, 0);

    // NACK reporting.
    wr(1'b0, 12'h777);
`ifdef DAC_SCHED_RETRY_EN
    run_retry_frame();
`else
    run_frame(1, 0, 1'b1);
`endif

    // Randomized traffic with injected writes.
    for (int it = 0; it < 25; it++) begin
      if (!m_pend[0] && !m_pend[1]) wr(1'($urandom_range(0, 1)), 12'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        wq_ch.push_back(1'($urandom_range(0, 1)));
        wq_v.push_back(12'($urandom));
      end
`ifdef DAC_SCHED_RETRY_EN
      run_frame(int'($urandom_range(0, 3)), wq_ch.size() + int'($urandom_range(0, 2)), 1'b0);
`else
      run_frame(int'($urandom_range(0, 3)), wq_ch.size() + int'($urandom_range(0, 2)),
                ($urandom_range(0, 7) == 0));
`endif
    end
    t = 0;
    while ((m_pend[0] || m_pend[1]) && t < 4) begin
      run_frame(0, 0, 1'b0);
      t++;
    end
    chk("drain_pending", {30'd0, pending}, 0);

    // Asynchronous reset while the frame is in B2.
    wr(1'b1, 12'h9E1);
    predict(ch6, v6);
    do_cmd(0);
    do_byte("r_b0", {4'b0000, ch6, 3'b000}, 1'b0, 0, 1'b0);
    do_byte("r_b1", {4'b0000, v6[11:8]}, 1'b0, 0, 1'b0);
    chk("r_b2_valid", {31'd0, bus.data_in_valid}, 1);
    wr_en = 1'b1; wr_channel = 1'b0; wr_value = 12'h123;
    #2 rst = 1'b0;
    #1;
    chk("async_data_valid", {31'd0, bus.data_in_valid}, 0);
    chk("async_pending", {30'd0, pending}, 0);
    chk("async_done", {31'd0, done}, 0);
    tick();
    wr_en = 1'b0;
    rst = 1'b1;
    bus.i2c_busy = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("post_rst_done", {31'd0, done}, 0);
    chk("post_rst_ready", {31'd0, sched_ready}, 0);
    chk("post_rst_cmd", {31'd0, bus.cmd_valid}, 0);
    chk("post_rst_err", {24'd0, err_count}, 0);

    // Back-to-back writes during startup: DAC0 wins the first tie.
    wr(1'b0, 12'h111);
    wr(1'b1, 12'h222);
    chk("pending_both", {30'd0, pending}, 2'b11);
    run_frame(0, 0, 1'b0);
    run_frame(2, 1, 1'b0);
    chk("pending_cleared", {30'd0, pending}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
